binary_divider_seq: RTL and testbench

Sequential restoring shift-subtract unsigned divider. It is the inverse companion of the shift-add multiplier and reuses the same G/LOAD/FINISH handshake, so the same datapath controller can drive either unit. Operands are loaded serially over a shared input bus, and the block resolves one quotient bit per two clock cycles. It delivers an N-bit quotient and an N-bit remainder, and flags division by zero.

---
 rtl/binary_divider_seq.sv | 134 +++++++++++++
 tb/tb_binary_divider_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/binary_divider_seq.sv
// Sequential restoring shift-subtract unsigned divider, one quotient bit per
// SHIFT/SUB pair, sharing the G/LOAD/FINISH handshake of the shift-add multiplier.
module binary_divider_seq #(
    parameter int N = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         G,
    input  logic         LOADD,
    input  logic         LOADV,
    input  logic [N-1:0] DIV_IN,
    output logic [N-1:0] QUOT_OUT,
    output logic [N-1:0] REM_OUT,
    output logic         DIV_FINISH,
    output logic         DIV_BY_ZERO
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        SUB   = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  b_q, b_d;
    logic [N:0]    a_q, a_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          fin_q, fin_d;
    logic          dbz_q, dbz_d;
    logic          zero_q, zero_d;
    logic [N:0]    diff;

    assign diff = a_q - {1'b0, b_q};

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        b_d     = b_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        fin_d   = fin_q;
        dbz_d   = dbz_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                fin_d = 1'b0;
                if (LOADD) q_d = DIV_IN;
                if (LOADV) b_d = DIV_IN;
                // Zero test uses the divisor as updated by this same edge's load.
                if (G) begin
                    if (b_d != '0) begin
                        a_d     = '0;
                        cnt_d   = CW'(N);
                        zero_d  = 1'b0;
                        state_d = SHIFT;
                    end else begin
                        zero_d  = 1'b1;
                        state_d = OUT;
                    end
                end
            end
            SHIFT: begin
                a_d     = {a_q[N-1:0], q_q[N-1]};
                q_d     = {q_q[N-2:0], 1'b0};
                state_d = SUB;
            end
            SUB: begin
                // Borrow in diff[N] means the trial subtract failed: keep A.
                if (!diff[N]) begin
                    a_d    = diff;
                    q_d[0] = 1'b1;
                end
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CW'(1)) ? OUT : SHIFT;
            end
            OUT: begin
                if (zero_q) begin
                    quot_d = '1;
                    rem_d  = q_q;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = q_q;
                    rem_d  = a_q[N-1:0];
                    dbz_d  = 1'b0;
                end
                fin_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (!G) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            q_q     <= '0;
            b_q     <= '0;
            a_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            fin_q   <= 1'b0;
            dbz_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            b_q     <= b_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            fin_q   <= fin_d;
            dbz_q   <= dbz_d;
            zero_q  <= zero_d;
        end
    end

    assign QUOT_OUT    = quot_q;
    assign REM_OUT     = rem_q;
    assign DIV_FINISH  = fin_q;
    assign DIV_BY_ZERO = dbz_q;
endmodule

// File: tb/tb_binary_divider_seq.sv
// Directed bench for binary_divider_seq (N=4): vector table plus corner sequences.
module tb_binary_divider_seq;
    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         G;
    logic         LOADD;
    logic         LOADV;
    logic [N-1:0] DIV_IN;
    logic [N-1:0] QUOT_OUT;
    logic [N-1:0] REM_OUT;
    logic         DIV_FINISH;
    logic         DIV_BY_ZERO;

    int ncmp = 0;
    int nerr = 0;

    binary_divider_seq #(.N(N)) dut (
        .CLK(CLK), .RESET(RESET), .G(G), .LOADD(LOADD), .LOADV(LOADV),
        .DIV_IN(DIV_IN), .QUOT_OUT(QUOT_OUT), .REM_OUT(REM_OUT),
        .DIV_FINISH(DIV_FINISH), .DIV_BY_ZERO(DIV_BY_ZERO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int dd;
        int dv;
        int eq;
        int er;
        int ez;
        int elat;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // G goes high with the given loads on the same edge (edge k).
    task automatic start(input logic ld, input logic lv, input int din);
        LOADD  = ld;
        LOADV  = lv;
        DIV_IN = din[N-1:0];
        G      = 1'b1;
        step();
        LOADD  = 1'b0;
        LOADV  = 1'b0;
    endtask

    // Edges after edge k until DIV_FINISH; 99 if it never rises.
    task automatic wait_fin(output int lat);
        lat = 0;
        while (!DIV_FINISH && lat < 40) begin
            step();
            lat++;
        end
        if (!DIV_FINISH) lat = 99;
    endtask

    task automatic release_g(input string name);
        G = 1'b0;
        step();
        chk({name, " fin_held_1st_edge"}, int'(DIV_FINISH), 1);
        step();
        chk({name, " fin_clear_2nd_edge"}, int'(DIV_FINISH), 0);
    endtask

    task automatic check_res(input string name, input int eq, input int er, input int ez);
        chk({name, " quot"}, int'(QUOT_OUT), eq);
        chk({name, " rem"}, int'(REM_OUT), er);
        chk({name, " dbz"}, int'(DIV_BY_ZERO), ez);
    endtask

    initial begin
        int lat;
        vecs[0] = '{13, 3, 4, 1, 0, 9};
        vecs[1] = '{5, 7, 0, 5, 0, 9};
        vecs[2] = '{15, 1, 15, 0, 0, 9};
        vecs[3] = '{15, 15, 1, 0, 0, 9};
        vecs[4] = '{7, 0, 15, 7, 1, 1};
        vecs[5] = '{0, 5, 0, 0, 0, 9};
        vecs[6] = '{9, 2, 4, 1, 0, 9};

        RESET = 1'b0; G = 1'b0; LOADD = 1'b0; LOADV = 1'b0; DIV_IN = '0;
        step();
        step();
        check_res("reset", 0, 0, 0);
        chk("reset fin", int'(DIV_FINISH), 0);
        RESET = 1'b1;

        // Dividend on its own edge, divisor on the G edge.
        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d %0d/%0d", i, vecs[i].dd, vecs[i].dv);
            LOADD = 1'b1; DIV_IN = vecs[i].dd[N-1:0];
            step();
            start(1'b0, 1'b1, vecs[i].dv);
            wait_fin(lat);
            chk({nm, " latency"}, lat, vecs[i].elat);
            check_res(nm, vecs[i].eq, vecs[i].er, vecs[i].ez);
            release_g(nm);
        end

        // Reset sampled at edge k+4 of a 13/3 divide (outputs hold 4/1 from 9/2).
        LOADD = 1'b1; DIV_IN = 4'd13;
        step();
        start(1'b0, 1'b1, 3);
        step(); step(); step();
        RESET = 1'b0;
        G = 1'b0;
        step();
        check_res("midreset", 0, 0, 0);
        chk("midreset fin", int'(DIV_FINISH), 0);
        RESET = 1'b1;
        repeat (12) step();
        chk("midreset no_resume fin", int'(DIV_FINISH), 0);
        LOADD = 1'b1; DIV_IN = 4'd9;
        step();
        start(1'b0, 1'b1, 2);
        wait_fin(lat);
        chk("after_reset 9/2 latency", lat, 9);
        check_res("after_reset 9/2", 4, 1, 0);

        // Hold G in DONE for 20 cycles with LOADD pulses; nothing may change.
        begin
            int bad_fin, bad_q, bad_r;
            bad_fin = 0; bad_q = 0; bad_r = 0;
            for (int c = 0; c < 20; c++) begin
                LOADD  = (c % 3 == 0);
                DIV_IN = 4'd6;
                step();
                if (!DIV_FINISH) bad_fin++;
                if (QUOT_OUT != 4'd4) bad_q++;
                if (REM_OUT != 4'd1) bad_r++;
            end
            LOADD = 1'b0;
            chk("done_hold fin_drops", bad_fin, 0);
            chk("done_hold quot_changes", bad_q, 0);
            chk("done_hold rem_changes", bad_r, 0);
        end
        release_g("done_hold");
        // Q now holds the last quotient (4); a divide by zero exposes it on REM_OUT.
        start(1'b0, 1'b1, 0);
        wait_fin(lat);
        chk("dividend_probe latency", lat, 1);
        check_res("dividend_probe", 15, 4, 1);
        release_g("dividend_probe");

        // Both loads and G on one edge: 9/9.
        start(1'b1, 1'b1, 9);
        wait_fin(lat);
        chk("same_edge latency", lat, 9);
        check_res("same_edge 9/9", 1, 0, 0);
        release_g("same_edge");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
